bipolar_3_level_decode: RTL and testbench
=========================================

BIPOLAR_3_LEVEL_DECODE -- requirements
Module: bipolar_3_level_decode

Interface
REQ-001 Parameter WIDTH, default 8: bits per deserialized output word.
REQ-002 Parameter CNT_W, default 16: width of the bipolar-violation counter.
REQ-003 CLK  input  1: single clock; all state updates on its rising edge.
REQ-004 CPU_RESET  input  1: reset, synchronous, active-low (0 = reset), sampled on CLK rising edge.
REQ-005 IN_VALID  input  1: line-symbol strobe; IN_ENCODED and IN_SIGN are sampled only when 1.
REQ-006 IN_ENCODED  input  1: line level; 0 = mark (data bit 1), 1 = space (data bit 0).
REQ-007 IN_SIGN  input  1: mark polarity, 1 = positive, 0 = negative; don't-care when IN_ENCODED=1.
REQ-008 CLR_ERR  input  1: one-cycle request to clear VIOL_CNT and OVERRUN.
REQ-009 OUT_READY  input  1: downstream accepts OUT_DATA when 1 with OUT_VALID=1.
REQ-010 OUT_DATA  output  WIDTH: decoded word; bit 0 = first received bit.
REQ-011 OUT_VALID  output  1: OUT_DATA holds an unaccepted word.
REQ-012 BPV  output  1: one-cycle pulse per detected bipolar violation.
REQ-013 VIOL_CNT  output  CNT_W: saturating count of bipolar violations.
REQ-014 OVERRUN  output  1: sticky; a completed word was dropped because OUT_VALID=1 and OUT_READY=0.

Function
REQ-015 The block SHALL decode each strobed symbol as data bit = ~IN_ENCODED, with no effect from IN_VALID=0 cycles.
REQ-016 The block SHALL shift decoded bits LSB-first into a WIDTH-bit shift register with a bit counter 0..WIDTH-1, wrapping to 0 after the WIDTH-th bit.
REQ-017 On the edge sampling the WIDTH-th bit, the completed word SHALL load OUT_DATA and OUT_VALID SHALL be 1 from the following cycle (latency 1 cycle).
REQ-018 OUT_VALID SHALL clear on an edge where OUT_VALID=1 and OUT_READY=1, unless a new word completes on that same edge, in which case the new word loads and OUT_VALID stays 1.
REQ-019 If a word completes while OUT_VALID=1 and OUT_READY=0, OUT_DATA SHALL remain unchanged, the new word SHALL be dropped, OUT_VALID SHALL stay 1 and OUT_OVERRUN SHALL set.
REQ-020 OUT_DATA SHALL be stable while OUT_VALID=1 and OUT_READY=0.
REQ-021 The block SHALL keep a last-mark polarity register and a have-mark flag (0 after reset).
REQ-022 On a strobed mark with have-mark=1 and IN_SIGN equal to the stored polarity, the block SHALL flag a violation; spaces between marks SHALL not affect the check.
REQ-023 Every strobed mark SHALL update the stored polarity to IN_SIGN and set have-mark; the first mark after reset SHALL never be a violation.
REQ-024 A violation SHALL still decode as data bit 1 (no bit substitution).
REQ-025 BPV SHALL be 1 for exactly the cycle after the sampling edge of the violating mark.
REQ-026 VIOL_CNT SHALL increment by 1 per violation and saturate at 2^CNT_W-1.
REQ-027 CLR_ERR=1 SHALL clear VIOL_CNT and OVERRUN; with a simultaneous violation VIOL_CNT SHALL become 1; with a simultaneous overrun OVERRUN SHALL stay 1.
REQ-028 CLR_ERR SHALL not affect the shift register, bit counter, polarity tracking or output handshake.

Reset
REQ-029 While CPU_RESET=0 at a rising edge: OUT_DATA=0, OUT_VALID=0, BPV=0, VIOL_CNT=0, OVERRUN=0, bit counter=0, shift register=0, have-mark=0, stored polarity=0.
REQ-030 Reset mid-word SHALL discard the partial word; decoding restarts at bit 0 with the first strobed symbol after CPU_RESET returns to 1.
REQ-031 Inputs SHALL be ignored during reset; no BPV pulse or count SHALL result from symbols presented during reset.

Verification
REQ-032 WIDTH=8; strobe symbols for bits 1,0,1,1,0,0,1,0 with alternating mark polarity +,-,+,- and OUT_READY=1 -> OUT_DATA=8'h4D, OUT_VALID high 1 cycle, BPV never 1, VIOL_CNT=0.
REQ-033 Strobed marks with polarity +,+ separated by 3 spaces -> one BPV pulse the cycle after the 2nd mark, VIOL_CNT=1, decoded bits 1,0,0,0,1.
REQ-034 OUT_READY=0; send two full words 8'hA5 then 8'h3C -> OUT_DATA stays 8'hA5, OVERRUN=1; then OUT_READY=1 for 1 cycle -> OUT_VALID=0; CLR_ERR pulse -> OVERRUN=0.
REQ-035 Force 2^CNT_W+2 violations (CNT_W=4 build: 18) -> VIOL_CNT=15 held; CLR_ERR on same edge as a violation -> VIOL_CNT=1.
REQ-036 Assert CPU_RESET=0 after 5 bits of a word, release, send 8 bits 8'hFF with alternating polarity -> OUT_DATA=8'hFF, first mark after reset gives no BPV.
REQ-037 Word completes on the edge OUT_VALID=1 and OUT_READY=1 -> new word loaded, OUT_VALID stays 1, OVERRUN stays 0.

Source files
------------

// File: rtl/bipolar_3_level_decode.sv
// Bipolar (AMI-style) three-level line decoder: deserializes strobed symbols LSB-first,
// flags bipolar violations, and hands complete words downstream over a valid/ready port.
module bipolar_3_level_decode #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             CPU_RESET,
   input  logic             IN_VALID,
   input  logic             IN_ENCODED,
   input  logic             IN_SIGN,
   input  logic             CLR_ERR,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] OUT_DATA,
   output logic             OUT_VALID,
   output logic             BPV,
   output logic [CNT_W-1:0] VIOL_CNT,
   output logic             OVERRUN
);

   localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   logic [WIDTH-1:0] shift_reg, shift_next;
   logic [BIT_W-1:0] bit_cnt_reg, bit_cnt_next;
   logic [WIDTH-1:0] out_data_reg, out_data_next;
   logic             out_valid_reg, out_valid_next;
   logic             bpv_reg, bpv_next;
   logic [CNT_W-1:0] viol_cnt_reg, viol_cnt_next;
   logic             overrun_reg, overrun_next;
   logic             pol_reg, pol_next;
   logic             have_mark_reg, have_mark_next;

   logic             data_bit;
   logic             is_mark;
   logic             viol;
   logic             word_done;
   logic             slot_free;
   logic [WIDTH-1:0] word_full;

   // A mark is the low line level; its polarity only matters relative to the previous mark.
   always_comb begin
      data_bit  = ~IN_ENCODED;
      is_mark   = IN_VALID & ~IN_ENCODED;
      viol      = is_mark & have_mark_reg & (IN_SIGN == pol_reg);
      word_done = IN_VALID & (bit_cnt_reg == LAST_BIT);
      slot_free = ~out_valid_reg | OUT_READY;
      word_full = {data_bit, shift_reg[WIDTH-1:1]};
   end

   always_comb begin
      shift_next     = shift_reg;
      bit_cnt_next   = bit_cnt_reg;
      pol_next       = pol_reg;
      have_mark_next = have_mark_reg;
      if (IN_VALID) begin
         shift_next   = word_full;
         bit_cnt_next = word_done ? '0 : bit_cnt_reg + 1'b1;
      end
      if (is_mark) begin
         pol_next       = IN_SIGN;
         have_mark_next = 1'b1;
      end
   end

   // A word completing while the held word is still pending is dropped, not queued.
   always_comb begin
      out_data_next  = out_data_reg;
      out_valid_next = out_valid_reg;
      if (word_done && slot_free) begin
         out_data_next  = word_full;
         out_valid_next = 1'b1;
      end else if (out_valid_reg && OUT_READY) begin
         out_valid_next = 1'b0;
      end
   end

   always_comb begin
      bpv_next      = viol;
      viol_cnt_next = viol_cnt_reg;
      overrun_next  = overrun_reg;
      if (CLR_ERR) begin
         viol_cnt_next = viol ? CNT_W'(1) : '0;
         overrun_next  = word_done & ~slot_free;
      end else begin
         if (viol && viol_cnt_reg != CNT_MAX)
            viol_cnt_next = viol_cnt_reg + 1'b1;
         if (word_done && !slot_free)
            overrun_next = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!CPU_RESET) begin
         shift_reg     <= '0;
         bit_cnt_reg   <= '0;
         out_data_reg  <= '0;
         out_valid_reg <= 1'b0;
         bpv_reg       <= 1'b0;
         viol_cnt_reg  <= '0;
         overrun_reg   <= 1'b0;
         pol_reg       <= 1'b0;
         have_mark_reg <= 1'b0;
      end else begin
         shift_reg     <= shift_next;
         bit_cnt_reg   <= bit_cnt_next;
         out_data_reg  <= out_data_next;
         out_valid_reg <= out_valid_next;
         bpv_reg       <= bpv_next;
         viol_cnt_reg  <= viol_cnt_next;
         overrun_reg   <= overrun_next;
         pol_reg       <= pol_next;
         have_mark_reg <= have_mark_next;
      end
   end

   assign OUT_DATA  = out_data_reg;
   assign OUT_VALID = out_valid_reg;
   assign BPV       = bpv_reg;
   assign VIOL_CNT  = viol_cnt_reg;
   assign OVERRUN   = overrun_reg;

endmodule

// File: tb/tb_bipolar_3_level_decode.sv
// Scoreboard bench for bipolar_3_level_decode: directed symbol streams, expected words queued
// by the stimulus and checked by an independent handshake monitor.
module tb_bipolar_3_level_decode;

   logic       CLK = 1'b0;
   logic       CPU_RESET;
   logic       IN_VALID;
   logic       IN_ENCODED;
   logic       IN_SIGN;
   logic       CLR_ERR;
   logic       OUT_READY;
   logic [7:0] OUT_DATA;
   logic       OUT_VALID;
   logic       BPV;
   logic [3:0] VIOL_CNT;
   logic       OVERRUN;

   int         n_cmp  = 0;
   int         n_fail = 0;
   int         bpv_seen = 0;
   int         valid_cycles = 0;
   logic [7:0] exp_q[$];
   logic       last_sign = 1'b0;

   bipolar_3_level_decode #(.WIDTH(8), .CNT_W(4)) dut (
      .CLK        (CLK),
      .CPU_RESET  (CPU_RESET),
      .IN_VALID   (IN_VALID),
      .IN_ENCODED (IN_ENCODED),
      .IN_SIGN    (IN_SIGN),
      .CLR_ERR    (CLR_ERR),
      .OUT_READY  (OUT_READY),
      .OUT_DATA   (OUT_DATA),
      .OUT_VALID  (OUT_VALID),
      .BPV        (BPV),
      .VIOL_CNT   (VIOL_CNT),
      .OVERRUN    (OVERRUN)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send_sym(input logic enc, input logic sgn);
      IN_VALID   = 1'b1;
      IN_ENCODED = enc;
      IN_SIGN    = sgn;
      if (!enc) last_sign = sgn;
      tick();
      IN_VALID   = 1'b0;
      IN_ENCODED = 1'b1;
   endtask

   // Marks alternate polarity so no violation is produced.
   task automatic send_bit(input logic b);
      if (b) send_sym(1'b0, ~last_sign);
      else   send_sym(1'b1, last_sign);
   endtask

   task automatic send_bits(input logic [7:0] w, input int n);
      for (int i = 0; i < n; i++) send_bit(w[i]);
   endtask

   task automatic clr_pulse();
      CLR_ERR = 1'b1;
      tick();
      CLR_ERR = 1'b0;
   endtask

   // Monitor: every accepted word is popped and compared against the scoreboard.
   initial begin
      logic [7:0] exp_w;
      forever begin
         @(negedge CLK);
         if (CPU_RESET) begin
            if (BPV) bpv_seen++;
            if (OUT_VALID) valid_cycles++;
            if (OUT_VALID && OUT_READY) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_word", {24'd0, OUT_DATA}, 32'hFFFF_FFFF);
               end else begin
                  exp_w = exp_q.pop_front();
                  $display("word accepted: data=%02h expected=%02h", OUT_DATA, exp_w);
                  check("out_data", {24'd0, OUT_DATA}, {24'd0, exp_w});
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int b0, v0;
      CPU_RESET  = 1'b0;
      IN_VALID   = 1'b0;
      IN_ENCODED = 1'b1;
      IN_SIGN    = 1'b0;
      CLR_ERR    = 1'b0;
      OUT_READY  = 1'b1;

      // Reset with same-polarity marks presented: they must be ignored.
      send_sym(1'b0, 1'b1);
      send_sym(1'b0, 1'b1);
      send_sym(1'b0, 1'b1);
      check("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
      check("rst_out_data",  {24'd0, OUT_DATA},  32'd0);
      check("rst_bpv",       {31'd0, BPV},       32'd0);
      check("rst_viol_cnt",  {28'd0, VIOL_CNT},  32'd0);
      check("rst_overrun",   {31'd0, OVERRUN},   32'd0);
      CPU_RESET = 1'b1;
      last_sign = 1'b0;
      tick();

      // Clean word 1,0,1,1,0,0,1,0 with marks +,-,+,-.
      b0 = bpv_seen;
      v0 = valid_cycles;
      exp_q.push_back(8'h4D);
      send_bits(8'h4D, 8);
      check("w4d_valid_now", {31'd0, OUT_VALID}, 32'd1);
      repeat (3) tick();
      check("w4d_valid_cycles", 32'(valid_cycles - v0), 32'd1);
      check("w4d_no_bpv",       32'(bpv_seen - b0),     32'd0);
      check("w4d_viol_cnt",     {28'd0, VIOL_CNT},      32'd0);

      // Marks +,+ separated by three spaces: one violation on the second mark.
      b0 = bpv_seen;
      send_sym(1'b0, 1'b1);
      send_sym(1'b1, 1'b0);
      send_sym(1'b1, 1'b1);
      send_sym(1'b1, 1'b0);
      send_sym(1'b0, 1'b1);
      check("bpv_pulse", {31'd0, BPV}, 32'd1);
      exp_q.push_back(8'h11);
      send_bits(8'h00, 3);
      check("bpv_one_cycle", {31'd0, BPV}, 32'd0);
      tick();
      check("bpv_count_once", 32'(bpv_seen - b0), 32'd1);
      check("viol_cnt_one",   {28'd0, VIOL_CNT},  32'd1);
      clr_pulse();
      check("viol_cnt_clr",   {28'd0, VIOL_CNT},  32'd0);

      // Overrun: second word dropped while the first is held.
      OUT_READY = 1'b0;
      exp_q.push_back(8'hA5);
      send_bits(8'hA5, 8);
      send_bits(8'h3C, 8);
      tick();
      check("ovr_data_held", {24'd0, OUT_DATA}, 32'hA5);
      check("ovr_valid",     {31'd0, OUT_VALID}, 32'd1);
      check("ovr_flag",      {31'd0, OVERRUN},   32'd1);
      OUT_READY = 1'b1;
      tick();
      OUT_READY = 1'b0;
      check("ovr_valid_clr", {31'd0, OUT_VALID}, 32'd0);
      check("ovr_sticky",    {31'd0, OVERRUN},   32'd1);
      clr_pulse();
      check("ovr_clr",       {31'd0, OVERRUN},   32'd0);

      // Counter saturation: 18 violations on a 4-bit counter.
      OUT_READY = 1'b1;
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'hFF);
      send_sym(1'b0, 1'b1);
      clr_pulse();
      b0 = bpv_seen;
      repeat (18) send_sym(1'b0, 1'b1);
      repeat (2) tick();
      check("sat_viol_cnt", {28'd0, VIOL_CNT},  32'd15);
      check("sat_bpv_count", 32'(bpv_seen - b0), 32'd18);
      CLR_ERR = 1'b1;
      send_sym(1'b0, 1'b1);
      CLR_ERR = 1'b0;
      check("clr_with_viol", {28'd0, VIOL_CNT}, 32'd1);

      // Reset after five bits of a word; symbols during reset are ignored.
      send_bit(1'b0);
      CPU_RESET = 1'b0;
      send_sym(1'b0, 1'b1);
      send_sym(1'b0, 1'b1);
      check("mid_rst_valid",    {31'd0, OUT_VALID}, 32'd0);
      check("mid_rst_data",     {24'd0, OUT_DATA},  32'd0);
      check("mid_rst_viol_cnt", {28'd0, VIOL_CNT},  32'd0);
      check("mid_rst_bpv",      {31'd0, BPV},       32'd0);
      CPU_RESET = 1'b1;
      last_sign = 1'b1;
      tick();
      b0 = bpv_seen;
      exp_q.push_back(8'hFF);
      send_bits(8'hFF, 8);
      repeat (2) tick();
      check("post_rst_no_bpv",   32'(bpv_seen - b0), 32'd0);
      check("post_rst_viol_cnt", {28'd0, VIOL_CNT},  32'd0);

      // Word completes on the same edge the held word is accepted.
      OUT_READY = 1'b0;
      exp_q.push_back(8'h5A);
      send_bits(8'h5A, 8);
      tick();
      check("b2b_first_valid", {31'd0, OUT_VALID}, 32'd1);
      exp_q.push_back(8'h69);
      send_bits(8'h69, 7);
      OUT_READY = 1'b1;
      send_bit(1'b0);
      check("b2b_valid_stays", {31'd0, OUT_VALID}, 32'd1);
      check("b2b_new_data",    {24'd0, OUT_DATA},  32'h69);
      check("b2b_no_overrun",  {31'd0, OVERRUN},   32'd0);
      repeat (2) tick();
      check("b2b_valid_done",  {31'd0, OUT_VALID}, 32'd0);
      check("b2b_overrun_end", {31'd0, OVERRUN},   32'd0);

      repeat (2) tick();
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
